wash_sequencer: RTL and testbench

WASH_SEQUENCER -- requirements
Module: wash_sequencer

---
 rtl/wash_sequencer_pkg.sv | 84 ++++++++
 rtl/wash_sequencer_count_down.sv | 40 ++++
 rtl/wash_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_wash_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// wash_sequencer_pkg
// Shared washer definitions: controller state encoding (also used by the
// STController), wash phase encoding, default durations, and small helpers
// for walking the pending-phase mask {spin, rinse, wash}.
// ---------------------------------------------------------------------------
package wash_sequencer_pkg;

  // Controller state as driven by the STController
  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6,
    ST_SLEEP    = 3'd7
  } washState_e;

  // Active program phase; bit position in the mask is (phase - 1)
  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WASH  = 2'd1,
    PH_RINSE = 2'd2,
    PH_SPIN  = 2'd3
  } washPhase_e;

  // Default durations in seconds
  localparam int DEF_INIT_T   = 5;
  localparam int DEF_FINISH_T = 5;
  localparam int DEF_SLEEP_T  = 3;
  localparam int DEF_WASH_T   = 9;
  localparam int DEF_RINSE_T  = 6;
  localparam int DEF_SPIN_T   = 3;

  // An empty program selection means "run every phase"
  localparam logic [2:0] ALL_PHASES = 3'b111;

  // Lowest pending phase wins: wash before rinse before spin
  function automatic logic [1:0] lowestPhase(input logic [2:0] m);
    if (m[0])      return PH_WASH;
    else if (m[1]) return PH_RINSE;
    else if (m[2]) return PH_SPIN;
    else           return PH_IDLE;
  endfunction

  // One-hot mask bit belonging to a phase
  function automatic logic [2:0] phaseBit(input logic [1:0] p);
    case (p)
      PH_WASH:  return 3'b001;
      PH_RINSE: return 3'b010;
      PH_SPIN:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  // Duration of a phase, given the three configured durations
  function automatic logic [3:0] phaseDuration(input logic [1:0] p,
                                               input logic [3:0] w,
                                               input logic [3:0] r,
                                               input logic [3:0] s);
    case (p)
      PH_WASH:  return w;
      PH_RINSE: return r;
      PH_SPIN:  return s;
      default:  return 4'd0;
    endcase
  endfunction

  // Total seconds for every phase enabled in the mask
  function automatic logic [5:0] programTotal(input logic [2:0] m,
                                              input logic [3:0] w,
                                              input logic [3:0] r,
                                              input logic [3:0] s);
    logic [5:0] total;
    total = 6'd0;
    if (m[0]) total = total + {2'b00, w};
    if (m[1]) total = total + {2'b00, r};
    if (m[2]) total = total + {2'b00, s};
    return total;
  endfunction

endpackage

// File: rtl/wash_sequencer_count_down.sv
// ---------------------------------------------------------------------------
// count_down
// Loadable saturating down counter used for the begin, finish and sleep
// countdowns.
//   cp        : clock, rising edge
//   resetBtn  : asynchronous active-low reset
//   clear     : synchronous return to zero (highest priority)
//   load      : load loadValue (beats tick in the same cycle)
//   tick      : decrement by one, holding at zero
//   loadValue : value taken on load
//   count     : current count
// ---------------------------------------------------------------------------
module count_down #(
  parameter int WIDTH = 3
) (
  input  logic             cp,
  input  logic             resetBtn,
  input  logic             clear,
  input  logic             load,
  input  logic             tick,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] count
);

  // Clear beats load beats tick, so an entry cycle that also carries a tick
  // lands exactly on the load value. The zero check makes the counter stick
  // at zero instead of wrapping.
  always_ff @(posedge cp or negedge resetBtn) begin
    if (!resetBtn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// ---------------------------------------------------------------------------
// wash_sequencer
// Datapath behind the washer controller: begin/finish/sleep countdowns and
// the wash -> rinse -> spin phase engine, all driven by the controller state.
//   cp         : clock, rising edge
//   resetBtn   : asynchronous active-low reset
//   tick       : one-cycle 1 Hz enable
//   state      : controller state (washState_e encoding)
//   modeSel    : program phase mask {spin, rinse, wash}, 0 selects all
//   initTime   : begin countdown
//   finishTime : finish buzzer countdown
//   sleepTime  : sleep hold countdown
//   hadFinish  : program completed, held until set or shutDown
//   shinning   : pending-phase mask {spin, rinse, wash}
//   phase      : 0 idle, 1 wash, 2 rinse, 3 spin
//   remainTime : total seconds left in the program
// ---------------------------------------------------------------------------
module wash_sequencer
  import wash_sequencer_pkg::*;
#(
  parameter int INIT_T   = DEF_INIT_T,
  parameter int FINISH_T = DEF_FINISH_T,
  parameter int SLEEP_T  = DEF_SLEEP_T,
  parameter int WASH_T   = DEF_WASH_T,
  parameter int RINSE_T  = DEF_RINSE_T,
  parameter int SPIN_T   = DEF_SPIN_T
) (
  input  logic       cp,
  input  logic       resetBtn,
  input  logic       tick,
  input  logic [2:0] state,
  input  logic [2:0] modeSel,
  output logic [2:0] initTime,
  output logic [2:0] finishTime,
  output logic [1:0] sleepTime,
  output logic       hadFinish,
  output logic [2:0] shinning,
  output logic [1:0] phase,
  output logic [5:0] remainTime
);

  localparam logic [3:0] WASH_D  = 4'(WASH_T);
  localparam logic [3:0] RINSE_D = 4'(RINSE_T);
  localparam logic [3:0] SPIN_D  = 4'(SPIN_T);

  washState_e curState;
  logic [2:0] prevState;
  logic       entry;
  logic       inShutDown;

  logic [2:0] mask;
  logic [3:0] phaseCnt;

  logic [2:0] maskNext;
  logic [2:0] shinNext;
  logic [1:0] phaseNext;
  logic [3:0] phaseCntNext;
  logic [5:0] remainNext;
  logic       hadFinishNext;
  logic [2:0] selMask;
  logic [2:0] clearedMask;

  assign curState   = washState_e'(state);
  assign entry      = (state != prevState);
  assign inShutDown = (curState == ST_SHUTDOWN);

  // Remember last cycle's state so a change of state can be seen as an
  // entry. Reset forces it to shutDown, which makes the first cycle after
  // release an entry whenever the controller is already elsewhere.
  always_ff @(posedge cp or negedge resetBtn) begin
    if (!resetBtn) begin
      prevState <= 3'd0;
    end else begin
      prevState <= state;
    end
  end

  // Each countdown loads on entry into its own state and only counts ticks
  // while that state persists, so ticks elsewhere have no effect.
  count_down #(.WIDTH(3)) initCounter (
    .cp        (cp),
    .resetBtn  (resetBtn),
    .clear     (inShutDown),
    .load      (entry && (curState == ST_BEGIN)),
    .tick      (tick && (curState == ST_BEGIN)),
    .loadValue (3'(INIT_T)),
    .count     (initTime)
  );

  count_down #(.WIDTH(3)) finishCounter (
    .cp        (cp),
    .resetBtn  (resetBtn),
    .clear     (inShutDown),
    .load      (entry && (curState == ST_FINISH)),
    .tick      (tick && (curState == ST_FINISH)),
    .loadValue (3'(FINISH_T)),
    .count     (finishTime)
  );

  count_down #(.WIDTH(2)) sleepCounter (
    .cp        (cp),
    .resetBtn  (resetBtn),
    .clear     (inShutDown),
    .load      (entry && (curState == ST_SLEEP)),
    .tick      (tick && (curState == ST_SLEEP)),
    .loadValue (2'(SLEEP_T)),
    .count     (sleepTime)
  );

  assign selMask     = (modeSel == 3'b000) ? ALL_PHASES : modeSel;
  assign clearedMask = shinning & ~phaseBit(phase);

  // Phase engine next-state. Set keeps reloading the program from modeSel
  // so the user can change the selection freely. Run consumes ticks; when
  // the current phase expires its bit is dropped and the next pending phase
  // is loaded in the same cycle, and dropping the last bit ends the
  // program. Every other state leaves the engine frozen, which is what lets
  // run resume after error, pause or sleep without any reload.
  always_comb begin
    maskNext      = mask;
    shinNext      = shinning;
    phaseNext     = phase;
    phaseCntNext  = phaseCnt;
    remainNext    = remainTime;
    hadFinishNext = hadFinish;
    case (curState)
      ST_SHUTDOWN: begin
        maskNext      = 3'b000;
        shinNext      = 3'b000;
        phaseNext     = PH_IDLE;
        phaseCntNext  = 4'd0;
        remainNext    = 6'd0;
        hadFinishNext = 1'b0;
      end
      ST_SET: begin
        maskNext      = selMask;
        shinNext      = selMask;
        phaseNext     = lowestPhase(selMask);
        phaseCntNext  = phaseDuration(lowestPhase(selMask), WASH_D, RINSE_D, SPIN_D);
        remainNext    = programTotal(selMask, WASH_D, RINSE_D, SPIN_D);
        hadFinishNext = 1'b0;
      end
      ST_RUN: begin
        if (tick && (phase != PH_IDLE)) begin
          if (phaseCnt <= 4'd1) begin
            shinNext = clearedMask;
            if (clearedMask == 3'b000) begin
              phaseNext     = PH_IDLE;
              phaseCntNext  = 4'd0;
              remainNext    = 6'd0;
              hadFinishNext = 1'b1;
            end else begin
              phaseNext    = lowestPhase(clearedMask);
              phaseCntNext = phaseDuration(lowestPhase(clearedMask), WASH_D, RINSE_D, SPIN_D);
              remainNext   = remainTime - 1'b1;
            end
          end else begin
            phaseCntNext = phaseCnt - 1'b1;
            remainNext   = remainTime - 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Phase engine registers; reset drives every output to zero immediately.
  always_ff @(posedge cp or negedge resetBtn) begin
    if (!resetBtn) begin
      mask       <= 3'b000;
      shinning   <= 3'b000;
      phase      <= PH_IDLE;
      phaseCnt   <= 4'd0;
      remainTime <= 6'd0;
      hadFinish  <= 1'b0;
    end else begin
      mask       <= maskNext;
      shinning   <= shinNext;
      phase      <= phaseNext;
      phaseCnt   <= phaseCntNext;
      remainTime <= remainNext;
      hadFinish  <= hadFinishNext;
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wash_sequencer
// Directed bench for wash_sequencer. Expected values are queued before each
// step is driven and popped once the step's clock edge has produced output.
// ---------------------------------------------------------------------------
module tb_wash_sequencer;
  import wash_sequencer_pkg::*;

  logic       cp = 1'b0;
  logic       resetBtn;
  logic       tick;
  logic [2:0] state;
  logic [2:0] modeSel;
  logic [2:0] initTime;
  logic [2:0] finishTime;
  logic [1:0] sleepTime;
  logic       hadFinish;
  logic [2:0] shinning;
  logic [1:0] phase;
  logic [5:0] remainTime;

  always #5 cp = ~cp;

  wash_sequencer dut (
    .cp         (cp),
    .resetBtn   (resetBtn),
    .tick       (tick),
    .state      (state),
    .modeSel    (modeSel),
    .initTime   (initTime),
    .finishTime (finishTime),
    .sleepTime  (sleepTime),
    .hadFinish  (hadFinish),
    .shinning   (shinning),
    .phase      (phase),
    .remainTime (remainTime)
  );

  typedef enum int {F_INIT, F_FINISH, F_SLEEP, F_HAD, F_SHIN, F_PHASE, F_REMAIN} field_e;
  typedef struct {
    string  tag;
    field_e field;
    int     value;
  } expect_t;

  expect_t sbQueue[$];
  int      checkCount = 0;
  int      passCount  = 0;
  int      failCount  = 0;

  // Current value of one observed output, zero-extended with X/Z kept
  function automatic logic [31:0] readField(input field_e f);
    case (f)
      F_INIT:   return 32'(initTime);
      F_FINISH: return 32'(finishTime);
      F_SLEEP:  return 32'(sleepTime);
      F_HAD:    return 32'(hadFinish);
      F_SHIN:   return 32'(shinning);
      F_PHASE:  return 32'(phase);
      default:  return 32'(remainTime);
    endcase
  endfunction

  // Queue one expected output value for the step about to be driven
  task automatic expectField(input string tag, input field_e f, input int v);
    expect_t e;
    e.tag   = tag;
    e.field = f;
    e.value = v;
    sbQueue.push_back(e);
  endtask

  // Queue the all-zero picture that reset and shutDown must produce
  task automatic expectAllZero(input string tag);
    expectField({tag, "_init"},   F_INIT,   0);
    expectField({tag, "_finish"}, F_FINISH, 0);
    expectField({tag, "_sleep"},  F_SLEEP,  0);
    expectField({tag, "_had"},    F_HAD,    0);
    expectField({tag, "_shin"},   F_SHIN,   0);
    expectField({tag, "_phase"},  F_PHASE,  0);
    expectField({tag, "_remain"}, F_REMAIN, 0);
  endtask

  // One clock step: inputs change #1 after the edge, tick lasts one cycle
  task automatic applyStimulus(input logic [2:0] s, input logic t, input logic [2:0] m);
    state   = s;
    tick    = t;
    modeSel = m;
    @(posedge cp);
    #1;
    tick = 1'b0;
  endtask

  // Drain the scoreboard against the outputs present right now
  task automatic checkOutput();
    expect_t     e;
    logic [31:0] obs;
    while (sbQueue.size() > 0) begin
      e   = sbQueue.pop_front();
      obs = readField(e.field);
      checkCount++;
      assert (obs === 32'(e.value)) passCount++;
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.value);
      end
    end
  endtask

  initial begin
    int expPhase;
    int expShin;

    resetBtn = 1'b0;
    tick     = 1'b0;
    state    = 3'd0;
    modeSel  = 3'd0;

    // Reset state
    repeat (2) @(posedge cp);
    #1;
    expectAllZero("reset");
    checkOutput();
    resetBtn = 1'b1;

    applyStimulus(ST_SHUTDOWN, 1'b1, 3'd0);
    expectAllZero("idleShutDown");
    checkOutput();

    // Begin countdown: load on entry, then 4,3,2,1,0 and hold
    expectField("beginLoad", F_INIT, 5);
    applyStimulus(ST_BEGIN, 1'b0, 3'd0);
    checkOutput();
    for (int i = 1; i <= 6; i++) begin
      expectField($sformatf("beginTick%0d", i), F_INIT, (i >= 5) ? 0 : 5 - i);
      applyStimulus(ST_BEGIN, 1'b1, 3'd0);
      checkOutput();
    end

    // Set reloads every cycle from modeSel; 0 means all phases
    expectField("set101_shin", F_SHIN, 5);
    expectField("set101_phase", F_PHASE, 1);
    expectField("set101_remain", F_REMAIN, 12);
    applyStimulus(ST_SET, 1'b0, 3'b101);
    checkOutput();
    expectField("set110_phase", F_PHASE, 2);
    expectField("set110_remain", F_REMAIN, 9);
    applyStimulus(ST_SET, 1'b1, 3'b110);
    checkOutput();
    expectField("setAll_shin", F_SHIN, 7);
    expectField("setAll_phase", F_PHASE, 1);
    expectField("setAll_remain", F_REMAIN, 18);
    expectField("setAll_had", F_HAD, 0);
    expectField("setAll_init", F_INIT, 0);
    applyStimulus(ST_SET, 1'b0, 3'b000);
    checkOutput();

    // Full program: wash 9, rinse 6, spin 3
    expectField("runEntry_remain", F_REMAIN, 18);
    applyStimulus(ST_RUN, 1'b0, 3'b000);
    checkOutput();
    for (int i = 1; i <= 18; i++) begin
      expPhase = (i < 9) ? 1 : (i < 15) ? 2 : (i < 18) ? 3 : 0;
      expShin  = (i < 9) ? 7 : (i < 15) ? 6 : (i < 18) ? 4 : 0;
      expectField($sformatf("runTick%0d_remain", i), F_REMAIN, 18 - i);
      expectField($sformatf("runTick%0d_phase", i), F_PHASE, expPhase);
      expectField($sformatf("runTick%0d_shin", i), F_SHIN, expShin);
      expectField($sformatf("runTick%0d_had", i), F_HAD, (i == 18) ? 1 : 0);
      applyStimulus(ST_RUN, 1'b1, 3'b000);
      checkOutput();
    end
    expectField("runDone_had", F_HAD, 1);
    expectField("runDone_remain", F_REMAIN, 0);
    applyStimulus(ST_RUN, 1'b1, 3'b000);
    checkOutput();

    // Finish countdown with hadFinish held
    expectField("finishLoad", F_FINISH, 5);
    expectField("finishLoad_had", F_HAD, 1);
    applyStimulus(ST_FINISH, 1'b0, 3'b000);
    checkOutput();
    for (int i = 1; i <= 6; i++) begin
      expectField($sformatf("finishTick%0d", i), F_FINISH, (i >= 5) ? 0 : 5 - i);
      applyStimulus(ST_FINISH, 1'b1, 3'b000);
      checkOutput();
    end
    expectField("finishHeld_had", F_HAD, 1);
    checkOutput();

    // Set after finish clears hadFinish and reloads rinse-only program
    expectField("reset010_had", F_HAD, 0);
    expectField("reset010_remain", F_REMAIN, 6);
    expectField("reset010_shin", F_SHIN, 2);
    expectField("reset010_phase", F_PHASE, 2);
    applyStimulus(ST_SET, 1'b0, 3'b010);
    checkOutput();

    // Four run ticks, then pause freezes remainTime at 2
    applyStimulus(ST_RUN, 1'b0, 3'b010);
    for (int i = 1; i <= 4; i++) begin
      expectField($sformatf("rinseTick%0d", i), F_REMAIN, 6 - i);
      applyStimulus(ST_RUN, 1'b1, 3'b010);
      checkOutput();
    end
    applyStimulus(ST_PAUSE, 1'b0, 3'b010);
    for (int i = 1; i <= 3; i++) begin
      expectField($sformatf("pauseTick%0d_remain", i), F_REMAIN, 2);
      expectField($sformatf("pauseTick%0d_phase", i), F_PHASE, 2);
      applyStimulus(ST_PAUSE, 1'b1, 3'b010);
      checkOutput();
    end
    expectField("resume_remain", F_REMAIN, 2);
    applyStimulus(ST_RUN, 1'b0, 3'b010);
    checkOutput();
    expectField("resumeTick1_remain", F_REMAIN, 1);
    expectField("resumeTick1_had", F_HAD, 0);
    applyStimulus(ST_RUN, 1'b1, 3'b010);
    checkOutput();
    expectField("resumeTick2_had", F_HAD, 1);
    expectField("resumeTick2_shin", F_SHIN, 0);
    expectField("resumeTick2_phase", F_PHASE, 0);
    expectField("resumeTick2_remain", F_REMAIN, 0);
    applyStimulus(ST_RUN, 1'b1, 3'b010);
    checkOutput();

    // Pause -> sleep with tick on the entry cycle: load wins
    applyStimulus(ST_SET, 1'b0, 3'b010);
    applyStimulus(ST_RUN, 1'b0, 3'b010);
    applyStimulus(ST_RUN, 1'b1, 3'b010);
    applyStimulus(ST_PAUSE, 1'b0, 3'b010);
    expectField("sleepLoad", F_SLEEP, 3);
    expectField("sleepLoad_remain", F_REMAIN, 5);
    applyStimulus(ST_SLEEP, 1'b1, 3'b010);
    checkOutput();
    for (int i = 1; i <= 4; i++) begin
      expectField($sformatf("sleepTick%0d", i), F_SLEEP, (i >= 3) ? 0 : 3 - i);
      expectField($sformatf("sleepTick%0d_remain", i), F_REMAIN, 5);
      applyStimulus(ST_SLEEP, 1'b1, 3'b010);
      checkOutput();
    end

    // Back in run on rinse, then reset between clock edges
    expectField("preReset_phase", F_PHASE, 2);
    applyStimulus(ST_RUN, 1'b0, 3'b010);
    checkOutput();
    #2;
    resetBtn = 1'b0;
    state    = ST_BEGIN;
    #1;
    expectAllZero("asyncReset");
    checkOutput();
    @(posedge cp);
    #1;
    expectAllZero("heldReset");
    checkOutput();
    resetBtn = 1'b1;

    // First cycle after release counts as entry into begin
    expectField("postReset_init", F_INIT, 5);
    applyStimulus(ST_BEGIN, 1'b0, 3'b000);
    checkOutput();

    // ShutDown clears everything
    expectField("preShut_remain", F_REMAIN, 18);
    applyStimulus(ST_SET, 1'b0, 3'b000);
    checkOutput();
    applyStimulus(ST_SHUTDOWN, 1'b1, 3'b000);
    expectAllZero("shutDown");
    checkOutput();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
